vector_mem_unit: RTL and testbench
==================================

// Module: vector_mem_unit
// PURPOSE
//  Memory-stage load/store sequencer; consumes the EX/MEM result (address) and store operand.
//  Serialises a VECTOR_SIZE x DATA_WIDTH vector (or one scalar) into byte-wide accesses on a
//  single-port data RAM with 1-cycle synchronous read. Gathers load bytes back into a vector.
//  Holds the pipeline through stall while the multi-beat transfer runs.
// PARAMETERS
//  DATA_WIDTH   8   lane width, equal to RAM word width
//  VECTOR_SIZE  6   lanes per vector, equal to beats per vector access
//  ADDR_WIDTH   16  RAM address width
// PORTS
//  clk             in   1                      clock, rising edge
//  reset           in   1                      synchronous, active-high
//  memRead         in   1                      load request, held by pipeline while stall=1
//  memWrite        in   1                      store request, held while stall=1
//  isScalarAccess  in   1                      1: single beat on lane 0; 0: VECTOR_SIZE beats
//  address         in   ADDR_WIDTH             base byte address (low bits of EX result)
//  writeData       in   DATA_WIDTH*VECTOR_SIZE store operand; lane k = bits [k*DW +: DW]
//  stall           out  1                      freeze IF..EX/MEM registers
//  readData        out  DATA_WIDTH*VECTOR_SIZE assembled load result (registered)
//  readValid       out  1                      readData valid this cycle (1-cycle pulse)
//  ramAddr         out  ADDR_WIDTH             RAM address
//  ramWriteEnable  out  1                      RAM write strobe
//  ramWriteData    out  DATA_WIDTH             RAM write byte
//  ramReadData     in   DATA_WIDTH             RAM read byte, valid the cycle after ramAddr
// BEHAVIOUR
//  Reset: state IDLE, beat counter 0, readData 0. While reset=1 stall, readValid and
//   ramWriteEnable are forced 0, and ramAddr and ramWriteData are 0.
//  N = 1 if isScalarAccess, else VECTOR_SIZE. Beat address = base+k mod 2^ADDR_WIDTH (wraps).
//  States IDLE, WRITE, READ, DRAIN, DONE.
//  IDLE: no request -> stall=0, no RAM access.
//   Request seen in cycle T -> stall=1 (combinational); latch address, writeData, N; k=0.
//   memWrite -> WRITE; memRead only -> READ.
//   memWrite&memRead -> write only; never assert readValid.
//  WRITE (T+1..T+N): ramWriteEnable=1, ramAddr=base+k, ramWriteData=lane k; k++.
//   stall=1 except on beat k=N-1, where stall=0. Next state IDLE.
//   Vector store: stall high T..T+5. Scalar store: stall high T only.
//  READ (T+1..T+N): ramWriteEnable=0, ramAddr=base+k, stall=1.
//   Byte returned for beat k-1 is stored into lane k-1. After the last issue -> DRAIN.
//  DRAIN (T+N+1): capture lane N-1 from ramReadData; stall=1 -> DONE.
//   Scalar load zero-fills lanes 1..VS-1.
//  DONE (T+N+2): readValid=1, stall=0, readData holds the assembled vector -> IDLE.
//   readData retains its value until the next load completes.
//  Non-memory instructions (memRead=memWrite=0): zero-latency pass, stall=0.
//  After stall deasserts, the pipeline advances. The next IDLE cycle samples the next
//   instruction; the same request is never re-issued.
//  Reset mid-operation: abort in the reset cycle. Beats already written stay in RAM, no
//   further beats. IDLE afterwards, readValid not pulsed.
//  ramAddr/ramWriteData don't-care when ramWriteEnable=0 outside READ; drive 0 in IDLE.
// TESTING
//  T1 vector store addr=0x0010 data=0x060504030201 -> T+1..T+6 writes 01..06 to 0x10..0x15.
//     stall high T..T+5, low T+6.
//  T2 vector load addr=0x0010 after T1 -> ramAddr 0x10..0x15 at T+1..T+6.
//     readData=0x060504030201 with readValid=1 at T+8 only; stall low at T+8.
//  T3 scalar store 0xAB to 0x0020, then scalar load 0x0020 -> store is 1 beat.
//     Load returns readData=0x0000000000AB at T+3.
//  T4 vector store addr=0xFFFE -> write addresses FFFE, FFFF, 0000, 0001, 0002, 0003.
//  T5 reset=1 in T+3 of T1 -> only beats T+1 and T+2 (0x10, 0x11) written.
//     stall=0 and ramWriteEnable=0 from T+3 on; IDLE at T+4.
//  T6 memRead=memWrite=1 vector at 0x0030 -> store sequence as T1; readValid stays 0.

Source files
------------

// File: rtl/vector_mem_unit.sv
// Memory-stage load/store sequencer: serialises a vector (or one scalar lane) into
// byte-wide beats on a single-port synchronous RAM and gathers load bytes back.
module vector_mem_unit #(
  parameter int DATA_WIDTH  = 8,
  parameter int VECTOR_SIZE = 6,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              memRead,
  input  logic                              memWrite,
  input  logic                              isScalarAccess,
  input  logic [ADDR_WIDTH-1:0]             address,
  input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] writeData,
  output logic                              stall,
  output logic [DATA_WIDTH*VECTOR_SIZE-1:0] readData,
  output logic                              readValid,
  output logic [ADDR_WIDTH-1:0]             ramAddr,
  output logic                              ramWriteEnable,
  output logic [DATA_WIDTH-1:0]             ramWriteData,
  input  logic [DATA_WIDTH-1:0]             ramReadData
);

  localparam int VW = DATA_WIDTH * VECTOR_SIZE;
  localparam int CW = $clog2(VECTOR_SIZE + 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t                state_reg;
  logic [CW-1:0]         beat_reg;
  logic [CW-1:0]         last_reg;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [VW-1:0]         wdata_reg;
  logic [VW-1:0]         gather_reg;
  logic [VW-1:0]         rdata_reg;

  logic                  request;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic                  capture_en;
  logic [CW-1:0]         capture_idx;
  logic [VW-1:0]         gather_next;

  assign request   = memRead | memWrite;
  assign beat_addr = base_reg + ADDR_WIDTH'(beat_reg);

  // RAM data lags the address by one cycle, so READ captures beat k-1 and DRAIN the last beat.
  assign capture_en  = ((state_reg == READ) && (beat_reg != '0)) || (state_reg == DRAIN);
  assign capture_idx = (state_reg == DRAIN) ? last_reg : beat_reg - CW'(1);

  generate
    for (genvar gi = 0; gi < VECTOR_SIZE; gi++) begin : g_lane
      assign gather_next[gi*DATA_WIDTH +: DATA_WIDTH] =
        (capture_en && (capture_idx == CW'(gi))) ? ramReadData
                                                 : gather_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      beat_reg   <= '0;
      last_reg   <= '0;
      base_reg   <= '0;
      wdata_reg  <= '0;
      gather_reg <= '0;
      rdata_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          beat_reg   <= '0;
          gather_reg <= '0;
          if (request) begin
            base_reg  <= address;
            wdata_reg <= writeData;
            last_reg  <= isScalarAccess ? '0 : CW'(VECTOR_SIZE - 1);
            state_reg <= memWrite ? WRITE : READ;
          end
        end
        WRITE: begin
          beat_reg <= beat_reg + CW'(1);
          if (beat_reg == last_reg) state_reg <= IDLE;
        end
        READ: begin
          gather_reg <= gather_next;
          beat_reg   <= beat_reg + CW'(1);
          if (beat_reg == last_reg) state_reg <= DRAIN;
        end
        DRAIN: begin
          gather_reg <= gather_next;
          rdata_reg  <= gather_next;
          state_reg  <= DONE;
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Stall drops on the final write beat so the pipeline advances as the store completes.
  always_comb begin
    stall          = 1'b0;
    readValid      = 1'b0;
    ramAddr        = '0;
    ramWriteEnable = 1'b0;
    ramWriteData   = '0;
    if (!reset) begin
      case (state_reg)
        IDLE:  stall = request;
        WRITE: begin
          ramWriteEnable = 1'b1;
          ramAddr        = beat_addr;
          ramWriteData   = wdata_reg[beat_reg*DATA_WIDTH +: DATA_WIDTH];
          stall          = (beat_reg != last_reg);
        end
        READ: begin
          ramAddr = beat_addr;
          stall   = 1'b1;
        end
        DRAIN: stall = 1'b1;
        DONE:  readValid = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  assign readData = rdata_reg;

endmodule

// File: tb/tb_vector_mem_unit.sv
// Scoreboard bench for vector_mem_unit: a shadow memory predicts RAM writes and
// assembled loads; a negedge monitor pops and compares them as the DUT produces them.
module tb_vector_mem_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        memRead, memWrite, isScalarAccess;
  logic [15:0] address;
  logic [47:0] writeData;
  logic        stall;
  logic [47:0] readData;
  logic        readValid;
  logic [15:0] ramAddr;
  logic        ramWriteEnable;
  logic [7:0]  ramWriteData;
  logic [7:0]  ramReadData;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  ram    [0:65535];
  logic [7:0]  shadow [0:65535];
  logic [23:0] wr_q [$];  // {addr, data}
  logic [47:0] rd_q [$];

  vector_mem_unit #(.DATA_WIDTH(8), .VECTOR_SIZE(6), .ADDR_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
    .isScalarAccess(isScalarAccess), .address(address), .writeData(writeData),
    .stall(stall), .readData(readData), .readValid(readValid), .ramAddr(ramAddr),
    .ramWriteEnable(ramWriteEnable), .ramWriteData(ramWriteData), .ramReadData(ramReadData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ramWriteEnable) ram[ramAddr] <= ramWriteData;
    ramReadData <= ram[ramAddr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: every RAM write and every readValid pulse must match a queued expectation.
  always @(negedge clk) begin
    if (ramWriteEnable) begin
      if (wr_q.size() == 0) chk("wr_unexpected", {ramAddr, ramWriteData}, 0);
      else begin
        logic [23:0] e;
        e = wr_q.pop_front();
        $display("wr addr=%04h data=%02h", ramAddr, ramWriteData);
        chk("wr_addr", ramAddr, e[23:8]);
        chk("wr_data", ramWriteData, e[7:0]);
      end
    end
    if (readValid) begin
      if (rd_q.size() == 0) chk("rv_unexpected", readValid, 0);
      else begin
        logic [47:0] e;
        e = rd_q.pop_front();
        $display("rd data=%012h", readData);
        chk("rd_data", readData, e);
      end
    end
  end

  function automatic void push_write(input logic sc, input logic [15:0] a,
                                     input logic [47:0] d, input int beats);
    for (int k = 0; k < beats; k++) begin
      logic [15:0] ba;
      ba = a + 16'(k);
      wr_q.push_back({ba, d[k*8 +: 8]});
      shadow[ba] = d[k*8 +: 8];
    end
  endfunction

  function automatic void push_read(input logic sc, input logic [15:0] a);
    logic [47:0] e;
    e = '0;
    for (int k = 0; k < (sc ? 1 : 6); k++) e[k*8 +: 8] = shadow[a + 16'(k)];
    rd_q.push_back(e);
  endfunction

  // Caller is positioned just after a rising edge (start of cycle T).
  task automatic run_op(input logic rd, input logic wr, input logic sc,
                        input logic [15:0] a, input logic [47:0] d, input string tag);
    int n;
    int exp_stall;
    bit done;
    if (wr) begin
      push_write(sc, a, d, sc ? 1 : 6);
      exp_stall = sc ? 1 : 6;
    end else if (rd) begin
      push_read(sc, a);
      exp_stall = sc ? 3 : 8;
    end else exp_stall = 0;
    memRead = rd; memWrite = wr; isScalarAccess = sc; address = a; writeData = d;
    n = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      if (!stall) done = 1;
      else begin
        n++;
        if (n > 20) begin
          chk({tag, "_timeout"}, n, exp_stall);
          done = 1;
        end
      end
    end
    chk({tag, "_stall_cycles"}, n, exp_stall);
    chk({tag, "_valid_at_release"}, readValid, rd && !wr);
    $display("op %s rd=%0d wr=%0d sc=%0d addr=%04h stall_cycles=%0d", tag, rd, wr, sc, a, n);
    @(posedge clk); #1;
    memRead = 0; memWrite = 0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 8'h00;
      shadow[i] = 8'h00;
    end
    reset = 1; memRead = 0; memWrite = 0; isScalarAccess = 0; address = '0; writeData = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_we", ramWriteEnable, 0);
    chk("rst_valid", readValid, 0);
    chk("rst_rdata", readData, 0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("idle_stall", stall, 0);
    chk("idle_addr", ramAddr, 0);
    @(posedge clk); #1;

    run_op(0, 1, 0, 16'h0010, 48'h060504030201, "t1_vst");
    run_op(0, 1, 0, 16'h0020, 48'h0, "t1b_vst_clear");
    run_op(1, 0, 0, 16'h0010, 48'h0, "t2_vld");
    run_op(0, 1, 1, 16'h0020, 48'h0000000000AB, "t3_sst");
    run_op(1, 0, 1, 16'h0020, 48'h0, "t3_sld");
    run_op(0, 0, 0, 16'h1234, 48'h0, "nop");
    run_op(0, 1, 0, 16'hFFFE, 48'hA6A5A4A3A2A1, "t4_wrap_st");
    run_op(1, 0, 0, 16'hFFFE, 48'h0, "t4_wrap_ld");
    run_op(1, 1, 0, 16'h0030, 48'h363534333231, "t6_rdwr");
    run_op(1, 0, 0, 16'h0030, 48'h0, "t6_ld");

    // Reset in T+3 of a vector store: only the first two beats may reach the RAM.
    push_write(0, 16'h0010, 48'hF6F5F4F3F2F1, 2);
    memWrite = 1; memRead = 0; isScalarAccess = 0; address = 16'h0010;
    writeData = 48'hF6F5F4F3F2F1;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("t5_stall_in_reset", stall, 0);
    chk("t5_we_in_reset", ramWriteEnable, 0);
    @(posedge clk); #1;
    reset = 0; memWrite = 0;
    @(negedge clk);
    chk("t5_stall_after", stall, 0);
    chk("t5_we_after", ramWriteEnable, 0);
    chk("t5_valid_after", readValid, 0);
    @(posedge clk); #1;
    run_op(1, 0, 0, 16'h0010, 48'h0, "t5_ld");

    for (int i = 0; i < 8; i++) begin
      logic [15:0] a;
      logic [47:0] d;
      int kind;
      a = 16'($urandom_range(0, 15)) + 16'hFFF8;
      d = {16'($urandom), 32'($urandom)};
      kind = $urandom_range(0, 3);
      run_op(kind[0], kind == 1 || kind == 3 ? 1'b0 : 1'b1, kind[1], a, d, "rnd");
    end

    repeat (4) @(posedge clk);
    chk("wr_queue_empty", wr_q.size(), 0);
    chk("rd_queue_empty", rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
